// File: rtl/decoder_pkg.sv
// Shared types and helpers for the decoder_scan one-hot decoder.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // A single-cycle dwell still needs a one-bit counter.
  function automatic int div_width(input int div);
    return (div <= 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/scan_divider.sv
// Dwell counter for scan mode: counts 0..SCAN_DIV-1 and ticks on the last count.
module scan_divider #(
  parameter int SCAN_DIV = 4,
  parameter int CNT_W    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en & (r_cnt == CNT_MAX);

  // Counter register; clear dominates enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_clr) begin
      r_cnt <= CNT_ZERO;
    end else if (i_en) begin
      if (r_cnt == CNT_MAX) begin
        r_cnt <= CNT_ZERO;
      end else begin
        r_cnt <= r_cnt + CNT_ONE;
      end
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Define DECODER_SCAN_PULSE_EN for single-cycle output pulses instead of levels.
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4,
  parameter int RST_IDX  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  w_valid,
  input  logic [SEL_W-1:0]      w,
  output logic                  w_ready,
  output logic [2**SEL_W-1:0]   out,
  output logic                  out_valid,
  output logic [SEL_W-1:0]      idx
);

  localparam int OUT_W = 2**SEL_W;
  localparam int CNT_W = div_width(SCAN_DIV);
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1'b1);
  localparam logic [OUT_W-1:0] OUT_ZERO = {OUT_W{1'b0}};
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1'b1);
  localparam logic [SEL_W-1:0] IDX_RST  = SEL_W'(RST_IDX);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_scan_entry;
  logic             w_scan_stay;
  logic             w_tick;
  logic [SEL_W-1:0] w_idx_inc;
  logic [OUT_W-1:0] r_out;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_idx;

  assign w_ready      = en & (mode == MODE_DIRECT);
  assign w_accept     = w_valid & w_ready;
  assign w_scan_entry = (w_next == SCAN) && (r_state != SCAN);
  assign w_scan_stay  = (w_next == SCAN) && (r_state == SCAN);
  assign w_idx_inc    = r_idx + IDX_ONE;

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign idx       = r_idx;

  scan_divider #(
    .SCAN_DIV (SCAN_DIV),
    .CNT_W    (CNT_W)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (~w_scan_stay),
    .i_en   (w_scan_stay),
    .o_tick (w_tick)
  );

  // Next state: en=0 wins, then scan mode; an accept in direct mode wins over leaving scan.
  always_comb begin
    w_next = r_state;
    if (!en) begin
      w_next = IDLE;
    end else if (mode == MODE_SCAN) begin
      w_next = SCAN;
    end else if (w_accept) begin
      w_next = DIRECT;
    end else if (r_state == SCAN) begin
      w_next = IDLE;
    end else begin
      w_next = r_state;
    end
  end

  // State, index and one-hot output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_out       <= OUT_ZERO;
      r_out_valid <= 1'b0;
      r_idx       <= IDX_RST;
    end else begin
      r_state <= w_next;
      if (w_next == IDLE) begin
        r_out       <= OUT_ZERO;
        r_out_valid <= 1'b0;
      end else if (w_scan_entry) begin
        r_idx       <= IDX_RST;
        r_out       <= OUT_ONE << IDX_RST;
        r_out_valid <= 1'b1;
      end else if (w_accept) begin
        r_idx       <= w;
        r_out       <= OUT_ONE << w;
        r_out_valid <= 1'b1;
      end else if (w_scan_stay && w_tick) begin
        r_idx       <= w_idx_inc;
        r_out       <= OUT_ONE << w_idx_inc;
        r_out_valid <= 1'b1;
      end else begin
`ifdef DECODER_SCAN_PULSE_EN
        r_out       <= OUT_ZERO;
        r_out_valid <= 1'b0;
`else
        r_out       <= r_out;
        r_out_valid <= r_out_valid;
`endif
      end
    end
  end

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan (level build, SEL_W=2, SCAN_DIV=3).
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       w_valid;
  logic [1:0] w;
  logic       w_ready;
  logic [3:0] out;
  logic       out_valid;
  logic [1:0] idx;

  int tests = 0;
  int fails = 0;

  decoder_scan #(.SEL_W(2), .SCAN_DIV(3), .RST_IDX(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .w_valid   (w_valid),
    .w         (w),
    .w_ready   (w_ready),
    .out       (out),
    .out_valid (out_valid),
    .idx       (idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; w_valid = 1'b0; w = 2'd0;
    #12;
    check("rst_out", 32'(out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_idx", 32'(idx), 32'h0);
    check("rst_ready", 32'(w_ready), 32'h0);
    rst_n = 1'b1;
    step();

    // Direct single accept and hold
    en = 1'b1; mode = 1'b0; w = 2'd2; w_valid = 1'b1;
    #1;
    check("dir_ready", 32'(w_ready), 32'h1);
    step();
    w_valid = 1'b0;
    check("dir_out", 32'(out), 32'h4);
    check("dir_valid", 32'(out_valid), 32'h1);
    check("dir_idx", 32'(idx), 32'h2);
    repeat (10) step();
    check("dir_hold", 32'(out), 32'h4);

    // Back-to-back accepts
    w_valid = 1'b1; w = 2'd0;
    step(); check("b2b_0", 32'(out), 32'h1);
    w = 2'd3;
    step(); check("b2b_3", 32'(out), 32'h8);
    w = 2'd1;
    step(); check("b2b_1", 32'(out), 32'h2);
    w_valid = 1'b0;
    step(); check("b2b_hold", 32'(out), 32'h2);

    // Scan walk with wrap; stray w_valid must be ignored
    mode = 1'b1; w_valid = 1'b1; w = 2'd3;
    #1;
    check("scan_ready", 32'(w_ready), 32'h0);
    for (int i = 0; i < 15; i++) begin
      step();
      check($sformatf("scan_out%0d", i), 32'(out), 32'(4'b0001 << ((i / 3) % 4)));
      check($sformatf("scan_vld%0d", i), 32'(out_valid), 32'h1);
    end
    repeat (4) step();
    check("scan_idx2", 32'(idx), 32'h2);
    check("scan_out2", 32'(out), 32'h4);

    // en drop with simultaneous w_valid, then re-enable
    en = 1'b0; w_valid = 1'b1; w = 2'd3;
    step();
    w_valid = 1'b0;
    check("endrop_out", 32'(out), 32'h0);
    check("endrop_valid", 32'(out_valid), 32'h0);
    check("endrop_idx", 32'(idx), 32'h2);
    step();
    check("endrop_noacc", 32'(out), 32'h0);
    en = 1'b1;
    step();
    check("reen_out", 32'(out), 32'h1);
    check("reen_idx", 32'(idx), 32'h0);
    repeat (3) step();
    check("reen_adv", 32'(out), 32'h2);

    // Mode falls: outputs clear, idx holds
    mode = 1'b0;
    step();
    check("mfall_out", 32'(out), 32'h0);
    check("mfall_valid", 32'(out_valid), 32'h0);
    check("mfall_idx", 32'(idx), 32'h1);

    // Asynchronous reset mid-scan at idx=2
    mode = 1'b1;
    step();
    repeat (6) step();
    check("pre_rst_idx", 32'(idx), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_idx", 32'(idx), 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_out", 32'(out), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
